i2s_tx: RTL and testbench

I2S master transmitter; the playback counterpart of the microphone capture path. Buffers stereo samples from the system side in a small FIFO and serialises them to an external I2S DAC/amplifier. Generates i2s_clk and i2s_ws, and drives i2s_sd in Philips format. It is instantiated beside the capture block in the FPGA top and shares its system clock.

---
 rtl/i2s_tx.sv | 214 +++++++++++++++++++++
 tb/tb_i2s_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx : I2S master transmitter (Philips format)
//
// Buffers stereo frames from the system side in a small FIFO and serialises
// them to an external I2S DAC. Generates the bit clock and word select from
// the system clock. Outputs change on falling edges of i2s_clk so the
// receiver samples on rising edges.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   enable         1 = run the interface, 0 = park it (outputs low)
//   sample_left    left-channel sample (two's complement, DATA_SIZE bits)
//   sample_right   right-channel sample
//   sample_valid   frame offered; accepted when valid && ready
//   sample_ready   FIFO not full
//   i2s_clk        bit clock
//   i2s_ws         word select (0 = left, 1 = right)
//   i2s_sd         serial data, MSB first, zero padded to 32-bit slots
//   fifo_empty     FIFO holds no frames
//   fifo_full      FIFO holds FIFO_DEPTH frames
//   fill_count     frames held in the FIFO
//   underrun       one-cycle pulse when a frame load finds the FIFO empty
//   underrun_count saturating count of underrun events
// -----------------------------------------------------------------------------
module i2s_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int I2S_CLK_FREQ = 1_500_000,
    parameter int DATA_SIZE    = 24,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] sample_left,
    input  logic [DATA_SIZE-1:0] sample_right,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 i2s_clk,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic [CNT_W-1:0]     fill_count,
    output logic                 underrun,
    output logic [7:0]           underrun_count
);

    localparam int DIV_RAW  = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int HALF_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // FIFO storage. Kept small and read asynchronously (distributed RAM) so
    // the head frame is available on the very cycle the frame load happens.
    logic [DATA_SIZE-1:0] r_mem_l [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] r_mem_r [FIFO_DEPTH];

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full;
    logic                 r_empty;

    logic [DIV_W-1:0]     r_div;
    logic                 r_sclk;
    logic                 r_ws;
    logic                 r_sd;
    logic [5:0]           r_bit_cnt;
    logic [DATA_SIZE-1:0] r_frame_l;
    logic [DATA_SIZE-1:0] r_frame_r;
    logic                 r_underrun;
    logic [7:0]           r_underrun_count;

    logic                 w_push;
    logic                 w_tick;
    logic                 w_fall;
    logic [5:0]           w_k;
    logic                 w_load;
    logic                 w_pop;
    logic                 w_underrun_ev;
    logic [DATA_SIZE-1:0] w_cur_l;
    logic [DATA_SIZE-1:0] w_cur_r;
    logic [DATA_SIZE-1:0] w_chan;
    logic [31:0]          w_pad;
    logic [4:0]           w_j;
    logic                 w_sd_bit;
    logic                 w_ws_bit;
    logic [CNT_W-1:0]     w_count_next;

    // Ready comes from the registered full flag only, so a pop in the same
    // cycle never makes room for a push.
    assign w_push        = sample_valid && !r_full;
    assign w_tick        = enable && (r_div == DIV_LAST);
    assign w_fall        = w_tick && r_sclk;
    assign w_k           = r_bit_cnt + 6'd1;
    assign w_load        = w_fall && (w_k == 6'd0);
    assign w_pop         = w_load && !r_empty;
    assign w_underrun_ev = w_load && r_empty;

    // On a load cycle the bit being emitted comes from the new frame (or
    // zeros on underrun), otherwise from the held frame register.
    always_comb begin
        w_cur_l = r_frame_l;
        w_cur_r = r_frame_r;
        if (w_load) begin
            if (r_empty) begin
                w_cur_l = '0;
                w_cur_r = '0;
            end else begin
                w_cur_l = r_mem_l[r_rd_ptr];
                w_cur_r = r_mem_r[r_rd_ptr];
            end
        end
    end

    // MSB-align the sample in a 32-bit slot; bits past DATA_SIZE are zero pad.
    assign w_chan   = w_k[5] ? w_cur_r : w_cur_l;
    assign w_pad    = 32'(w_chan) << (32 - DATA_SIZE);
    assign w_j      = w_k[4:0];
    assign w_sd_bit = w_pad[5'd31 - w_j];
    // Word select switches one bit before the MSB of the next slot.
    assign w_ws_bit = (w_k >= 6'd31) && (w_k <= 6'd62);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_l[r_wr_ptr] <= sample_left;
            r_mem_r[r_wr_ptr] <= sample_right;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_full           <= 1'b0;
            r_empty          <= 1'b1;
            r_div            <= '0;
            r_sclk           <= 1'b0;
            r_ws             <= 1'b0;
            r_sd             <= 1'b0;
            r_bit_cnt        <= 6'd63;
            r_frame_l        <= '0;
            r_frame_r        <= '0;
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_FULL);
            r_empty <= (w_count_next == '0);

            if (!enable) begin
                // Park: any partial frame is dropped, restart at frame start.
                r_div     <= '0;
                r_sclk    <= 1'b0;
                r_ws      <= 1'b0;
                r_sd      <= 1'b0;
                r_bit_cnt <= 6'd63;
                r_frame_l <= '0;
                r_frame_r <= '0;
            end else if (w_tick) begin
                r_div  <= '0;
                r_sclk <= !r_sclk;
                if (r_sclk) begin
                    r_bit_cnt <= w_k;
                    r_ws      <= w_ws_bit;
                    r_sd      <= w_sd_bit;
                    if (w_load) begin
                        r_frame_l <= w_cur_l;
                        r_frame_r <= w_cur_r;
                    end
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            r_underrun <= w_underrun_ev;
            if (w_underrun_ev && (r_underrun_count != 8'hFF)) begin
                r_underrun_count <= r_underrun_count + 8'd1;
            end
        end
    end

    assign sample_ready   = !r_full;
    assign i2s_clk        = r_sclk;
    assign i2s_ws         = r_ws;
    assign i2s_sd         = r_sd;
    assign fifo_empty     = r_empty;
    assign fifo_full      = r_full;
    assign fill_count     = r_count;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx : self-checking bench for i2s_tx
//
// Runs the DUT with a 2-cycle half bit period so a 64-bit frame is 256 clk
// cycles. A receiver model samples i2s_sd on rising edges of i2s_clk, checks
// word select per bit, and compares each received frame against a
// scoreboard queue filled when frames are pushed into the DUT.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

    localparam int DS    = 24;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DS-1:0] sample_left = '0;
    logic [DS-1:0] sample_right = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          i2s_clk;
    logic          i2s_ws;
    logic          i2s_sd;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fill_count;
    logic          underrun;
    logic [7:0]    underrun_count;

    always #5 clk = ~clk;

    i2s_tx #(
        .CLK_FREQ     (50_000_000),
        .I2S_CLK_FREQ (12_500_000),
        .DATA_SIZE    (DS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample_left    (sample_left),
        .sample_right   (sample_right),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .i2s_clk        (i2s_clk),
        .i2s_ws         (i2s_ws),
        .i2s_sd         (i2s_sd),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fill_count     (fill_count),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wire_word(input logic [DS-1:0] l, input logic [DS-1:0] r);
        return {l, {(32-DS){1'b0}}, r, {(32-DS){1'b0}}};
    endfunction

    logic [63:0] sb_q[$];

    // ---------------- receiver / monitor ----------------
    logic        prev_sclk = 1'b0;
    logic        prev_und = 1'b0;
    int          rise_idx = 0;
    int          cur_k = -1;
    logic [63:0] shreg = '0;
    logic [63:0] cur_exp = '0;
    bit          cur_valid = 1'b0;
    int          frames_done = 0;
    int          und_pulses = 0;
    int          und_last_cyc = 0;
    int          cyc = 0;

    always @(negedge clk) begin
        int k;
        cyc++;
        if (underrun) begin
            check("und_width", 64'(prev_und), 64'd0);
            und_pulses++;
            und_last_cyc = cyc;
        end
        prev_und = underrun;
        if (!rst_n || !enable) begin
            rise_idx  = 0;
            cur_k     = -1;
            cur_valid = 1'b0;
        end else if (i2s_clk && !prev_sclk) begin
            k = (rise_idx + 63) % 64;
            rise_idx++;
            cur_k = k;
            check("ws", 64'(i2s_ws), 64'(k >= 31 && k <= 62));
            if (k == 0) begin
                cur_exp   = (sb_q.size() > 0) ? sb_q.pop_front() : 64'd0;
                cur_valid = 1'b1;
                shreg     = '0;
            end
            if (k == 63 && !cur_valid) begin
                check("sd_idle", 64'(i2s_sd), 64'd0);
            end
            shreg = {shreg[62:0], i2s_sd};
            if (k == 63 && cur_valid) begin
                check("frame", shreg, cur_exp);
                $display("frame %0d rx %016h exp %016h", frames_done, shreg, cur_exp);
                frames_done++;
                cur_valid = 1'b0;
            end
        end
        prev_sclk = i2s_clk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [DS-1:0] l, input logic [DS-1:0] r, output bit accepted);
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        accepted     = sample_ready;
        tick(1);
        sample_valid = 1'b0;
        if (accepted) sb_q.push_back(wire_word(l, r));
    endtask

    task automatic wait_frames(input int n, input string tag);
        int target;
        int t;
        target = frames_done + n;
        t = 0;
        while (frames_done < target && t < n * FRAME + 800) begin
            tick(1);
            t++;
        end
        check(tag, 64'(frames_done >= target), 64'd1);
    endtask

    task automatic wait_k(input int kk, input string tag);
        int t;
        t = 0;
        while (cur_k != kk && t < 2 * FRAME) begin
            tick(1);
            t++;
        end
        check(tag, 64'(cur_k), 64'(kk));
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        rst_n  = 1'b1;
        sb_q.delete();
        tick(1);
    endtask

    initial begin
        int n;
        int u0;
        int c1;
        int t;
        bit acc;
        int acc_cnt;

        // ---- T1: reset values and bit clock shape ----
        rst_n = 1'b0;
        tick(2);
        check("rst_sclk", 64'(i2s_clk), 64'd0);
        check("rst_ws", 64'(i2s_ws), 64'd0);
        check("rst_sd", 64'(i2s_sd), 64'd0);
        check("rst_fill", 64'(fill_count), 64'd0);
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_ready", 64'(sample_ready), 64'd1);
        check("rst_und", 64'(underrun), 64'd0);
        check("rst_undcnt", 64'(underrun_count), 64'd0);
        rst_n = 1'b1;
        tick(1);

        enable = 1'b1;
        n = 0;
        while (!i2s_clk && n < 50) begin tick(1); n++; end
        check("first_rise", 64'(n), 64'd2);
        n = 0;
        while (i2s_clk && n < 50) begin tick(1); n++; end
        check("sclk_high", 64'(n), 64'd2);
        n = 0;
        while (!i2s_clk && n < 50) begin tick(1); n++; end
        check("sclk_low", 64'(n), 64'd2);

        u0 = und_pulses;
        t = 0;
        while (und_pulses < u0 + 1 && t < 2 * FRAME) begin tick(1); t++; end
        c1 = und_last_cyc;
        t = 0;
        while (und_pulses < u0 + 2 && t < 2 * FRAME) begin tick(1); t++; end
        check("und_spacing", 64'(und_last_cyc - c1), 64'(FRAME));

        // ---- T2: single known frame ----
        do_reset();
        push_frame(24'hABCDEF, 24'h123456, acc);
        check("t2_acc", 64'(acc), 64'd1);
        tick(1);
        enable = 1'b1;
        wait_frames(1, "t2_wait");
        check("t2_undcnt", 64'(underrun_count), 64'd0);

        // ---- T3: empty FIFO, underrun saturation ----
        do_reset();
        u0 = und_pulses;
        enable = 1'b1;
        wait_frames(257, "t3_wait");
        check("t3_undcnt", 64'(underrun_count), 64'd255);
        check("t3_pulses", 64'(und_pulses - u0), 64'd257);

        // ---- T4: fill while parked, then drain in order ----
        do_reset();
        acc_cnt = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_frame(DS'(24'hA5A5A5 ^ (i * 24'h010203)), DS'(24'h0F0F00 + i), acc);
            if (acc) acc_cnt++;
        end
        check("t4_accepted", 64'(acc_cnt), 64'(DEPTH));
        check("t4_fill", 64'(fill_count), 64'(DEPTH));
        check("t4_full", 64'(fifo_full), 64'd1);
        check("t4_ready", 64'(sample_ready), 64'd0);
        sample_valid = 1'b1;
        tick(3);
        check("t4_held", 64'(fill_count), 64'(DEPTH));
        sample_valid = 1'b0;
        enable = 1'b1;
        wait_frames(DEPTH, "t4_wait");
        check("t4_empty", 64'(fifo_empty), 64'd1);
        u0 = und_pulses;
        t = 0;
        while (und_pulses == u0 && t < FRAME) begin tick(1); t++; end
        check("t4_underrun", 64'(und_pulses - u0), 64'd1);

        // ---- T5: drop enable mid-frame ----
        do_reset();
        push_frame(24'h800001, 24'h7FFFFE, acc);
        push_frame(24'h13579B, 24'h2468AC, acc);
        push_frame(24'hFEDCBA, 24'h010203, acc);
        enable = 1'b1;
        wait_k(40, "t5_k40");
        check("t5_ws_before", 64'(i2s_ws), 64'd1);
        enable = 1'b0;
        tick(1);
        check("t5_sclk", 64'(i2s_clk), 64'd0);
        check("t5_ws", 64'(i2s_ws), 64'd0);
        check("t5_sd", 64'(i2s_sd), 64'd0);
        check("t5_fill", 64'(fill_count), 64'd2);
        tick(5);
        enable = 1'b1;
        wait_frames(2, "t5_wait");
        check("t5_fill_end", 64'(fill_count), 64'd0);

        // ---- T6: reset mid-frame ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_frame(DS'(24'h300000 + i), DS'(24'hC00000 - i), acc);
        end
        enable = 1'b1;
        wait_k(10, "t6_k10");
        check("t6_fill5", 64'(fill_count), 64'd5);
        rst_n  = 1'b0;
        enable = 1'b0;
        tick(1);
        check("t6_sclk", 64'(i2s_clk), 64'd0);
        check("t6_ws", 64'(i2s_ws), 64'd0);
        check("t6_sd", 64'(i2s_sd), 64'd0);
        check("t6_fill", 64'(fill_count), 64'd0);
        check("t6_ready", 64'(sample_ready), 64'd1);
        check("t6_empty", 64'(fifo_empty), 64'd1);
        rst_n = 1'b1;
        sb_q.delete();
        tick(1);
        push_frame(24'h5A5A5A, 24'hC3C3C3, acc);
        enable = 1'b1;
        wait_frames(1, "t6_wait");
        check("t6_fill_end", 64'(fill_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
